// File: rtl/prog_seq_pkg.sv
// Shared types and helpers for the program sequencer.
// Holds the FSM state encoding, default widths and the entry-PC selector.
`timescale 1ns/1ps
package prog_seq_pkg;

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_START  = 3'd1,
        S_RUN    = 3'd2,
        S_LATCH  = 3'd3,
        S_FINISH = 3'd4,
        S_ERROR  = 3'd5
    } seq_state_t;

    localparam int PC_W_DEF  = 12;
    localparam int CNT_W_DEF = 12;
    // Widest PC the entry-PC helper can handle.
    localparam int MAX_PC_W  = 32;

    // Returns slot idx of a packed 4-slot entry-PC table whose slots are
    // pc_w bits wide. Only the low pc_w bits of the result are meaningful;
    // callers truncate to their own PC width.
    function automatic logic [MAX_PC_W-1:0] base_of(
        input logic [4*MAX_PC_W-1:0] bases,
        input int                    pc_w,
        input logic [1:0]            idx
    );
        logic [4*MAX_PC_W-1:0] shifted;
        shifted = bases >> (int'(idx) * pc_w);
        return shifted[MAX_PC_W-1:0];
    endfunction

endpackage

// File: rtl/prog_sequencer_counter.sv
// seq_counter: loadable counter that can count down to 0 or up to MAX and
// saturates at both ends. Load has priority over decrement, which has
// priority over increment.
`timescale 1ns/1ps
module seq_counter #(
    parameter int W   = 8,
    parameter int MAX = 255
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         load,
    input  logic [W-1:0] load_val,
    input  logic         dec,
    input  logic         inc,
    output logic [W-1:0] count
);

    // Counter register with saturation at 0 and MAX.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            count <= '0;
        end else if (load) begin
            count <= load_val;
        end else if (dec) begin
            if (count != '0) count <= count - W'(1);
        end else if (inc) begin
            if (count != W'(MAX)) count <= count + W'(1);
        end
    end

endmodule

// File: rtl/prog_sequencer.sv
// prog_sequencer: runs NUM_PROGS programs on the core one after another.
// For each program it pulses core_start for START_CYCLES cycles with the
// entry PC on core_pc_init, counts run cycles until core_done, and latches
// the count. A run that reaches MAX_CYCLES parks the block in ERROR.
// Optional feature macro: CYCLE_LOG_EN keeps a per-program cycle log
// readable through log_idx/log_count.
// Handshake: go is a level request sampled only in IDLE (and watched for
// its fall in FINISH); core_done is sampled only in RUN; core_start is a
// level held for exactly START_CYCLES cycles per program.
`timescale 1ns/1ps
module prog_sequencer
    import prog_seq_pkg::*;
#(
    parameter int                NUM_PROGS    = 3,
    parameter int                PC_W         = PC_W_DEF,
    parameter logic [4*PC_W-1:0] PROG_BASES   = '0,
    parameter int                START_CYCLES = 2,
    parameter int                MAX_CYCLES   = 4095,
    localparam int               CNT_W        = $clog2(MAX_CYCLES + 1)
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             go,
    input  logic             core_done,
    output logic             core_start,
    output logic [PC_W-1:0]  core_pc_init,
    output logic [1:0]       prog_idx,
    output logic             busy,
    output logic [CNT_W-1:0] cycle_count,
    output logic             all_done,
    output logic             timeout_err,
    input  logic [1:0]       log_idx,
    output logic [CNT_W-1:0] log_count,
    output seq_state_t       state_dbg
);

    localparam int SC_W = $clog2(START_CYCLES + 1);
    localparam int BW   = 4 * MAX_PC_W;
    localparam logic [BW-1:0] BASES_EXT = BW'(PROG_BASES);

    seq_state_t        state, state_next;
    logic [SC_W-1:0]   start_cnt;
    logic [CNT_W-1:0]  run_cnt;
    logic              start_load, start_dec, run_clr, run_inc;
    logic              is_last, run_at_limit;

    assign is_last      = (prog_idx == 2'(NUM_PROGS - 1));
    // run_cnt excludes the current RUN cycle, so the limit is hit when the
    // cycle being counted now is the MAX_CYCLES-th one.
    assign run_at_limit = (run_cnt >= CNT_W'(MAX_CYCLES - 1));

    assign core_pc_init = PC_W'(base_of(BASES_EXT, PC_W, prog_idx));
    assign core_start   = (state == S_START);
    assign busy         = (state == S_START) || (state == S_RUN) || (state == S_LATCH);
    assign timeout_err  = (state == S_ERROR);
    assign state_dbg    = state;

    seq_counter #(.W(SC_W), .MAX(START_CYCLES)) u_start_cnt (
        .clk      (clk),
        .rst      (reset),
        .load     (start_load),
        .load_val (SC_W'(START_CYCLES)),
        .dec      (start_dec),
        .inc      (1'b0),
        .count    (start_cnt)
    );

    seq_counter #(.W(CNT_W), .MAX(MAX_CYCLES)) u_run_cnt (
        .clk      (clk),
        .rst      (reset),
        .load     (run_clr),
        .load_val ('0),
        .dec      (1'b0),
        .inc      (run_inc),
        .count    (run_cnt)
    );

    // State register.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) state <= S_IDLE;
        else       state <= state_next;
    end

    // Next-state and counter control.
    always_comb begin
        state_next = state;
        start_load = 1'b0;
        start_dec  = 1'b0;
        run_clr    = 1'b0;
        run_inc    = 1'b0;
        case (state)
            S_IDLE: begin
                if (go) begin
                    start_load = 1'b1;
                    state_next = S_START;
                end
            end
            S_START: begin
                // core_done is undefined while the core is being started.
                start_dec = 1'b1;
                run_clr   = 1'b1;
                if (start_cnt == SC_W'(1)) state_next = S_RUN;
            end
            S_RUN: begin
                run_inc = 1'b1;
                if (core_done)         state_next = S_LATCH;
                else if (run_at_limit) state_next = S_ERROR;
            end
            S_LATCH: begin
                if (is_last) begin
                    state_next = S_FINISH;
                end else begin
                    start_load = 1'b1;
                    state_next = S_START;
                end
            end
            S_FINISH: begin
                if (!go) state_next = S_IDLE;
            end
            S_ERROR: state_next = S_ERROR;
            default: state_next = S_IDLE;
        endcase
    end

    // Program index, latched cycle count and sequence-complete flag.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            prog_idx    <= '0;
            cycle_count <= '0;
            all_done    <= 1'b0;
        end else begin
            if (state == S_IDLE && go) begin
                prog_idx <= '0;
                all_done <= 1'b0;
            end
            if (state == S_LATCH) begin
                cycle_count <= run_cnt;
                if (is_last) all_done <= 1'b1;
                else         prog_idx <= prog_idx + 2'd1;
            end
        end
    end

`ifdef CYCLE_LOG_EN
    logic [CNT_W-1:0] log_mem [NUM_PROGS];

    // Per-program cycle log, cleared whenever a new sequence begins.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < NUM_PROGS; i++) log_mem[i] <= '0;
        end else if (state == S_IDLE && go) begin
            for (int i = 0; i < NUM_PROGS; i++) log_mem[i] <= '0;
        end else if (state == S_LATCH) begin
            log_mem[prog_idx] <= run_cnt;
        end
    end

    // Combinational log read; indices past the last program read as 0.
    always_comb begin
        log_count = '0;
        if (int'(log_idx) < NUM_PROGS) log_count = log_mem[log_idx];
    end
`else
    logic log_idx_unused;
    assign log_idx_unused = ^log_idx;
    assign log_count      = '0;
`endif

endmodule

// File: doc/prog_sequencer.md
Name: prog_sequencer

Overview:
Top-level run controller for the 9-bit single-cycle core. Drives the core's start, supplies the program entry PC, and waits for the core's done for each of NUM_PROGS programs in turn. Counts the execution cycles of each program and flags a hung program through a watchdog. Sits between the testbench or host and the core.

Parameters:
NUM_PROGS, 3, number of programs run back-to-back (1..4)
PC_W, 12, program counter width
PROG_BASES, {12'd0,12'd0,12'd0,12'd0}, packed entry PCs; slot i at bits [i*PC_W +: PC_W]
START_CYCLES, 2, cycles core_start is held high per program (>=1)
MAX_CYCLES, 4095, watchdog limit in RUN state; CNT_W = $clog2(MAX_CYCLES+1)

Ports:
clk  in  1  system clock
reset  in  1  asynchronous, active-high reset
go  in  1  request to run the full program sequence; sampled only in IDLE
core_done  in  1  done from the core's controller
core_start  out  1  start to the core; the core PC loads core_pc_init while this is high
core_pc_init  out  PC_W  entry PC of the current program
prog_idx  out  2  index of the current or last program
busy  out  1  high in every state except IDLE, FINISH and ERROR
cycle_count  out  CNT_W  cycle count of the last completed program
all_done  out  1  level; sequence completed
timeout_err  out  1  level; watchdog expired
log_idx  in  2  read index for the cycle log (CYCLE_LOG_EN only)
log_count  out  CNT_W  logged count at log_idx (CYCLE_LOG_EN only)

Behaviour:
- Reset is asynchronous and active-high. Every output and register goes to 0 and the FSM goes to IDLE.
- States: IDLE, START, RUN, LATCH, FINISH, ERROR.
- IDLE: when go=1, set prog_idx=0, load the start counter with START_CYCLES and go to START. When go=0, stay in IDLE.
- START:
  - core_start=1 and core_pc_init=PROG_BASES[prog_idx].
  - The start counter decrements each cycle; when it reaches 1, go to RUN on the next edge.
  - core_done is ignored in this state, because the core's done is undefined while start is high.
  - The run counter is cleared to 0.
- RUN:
  - core_start=0.
  - The run counter increments every cycle.
  - If core_done=1, go to LATCH. The counted cycles include the cycle in which done is seen.
  - Else if the run counter == MAX_CYCLES, go to ERROR.
  - If done and the limit occur in the same cycle, done wins.
- LATCH (one cycle):
  - cycle_count <= run counter.
  - If prog_idx == NUM_PROGS-1, go to FINISH.
  - Else increment prog_idx, reload the start counter and go to START.
- FINISH: all_done=1 and busy=0. The block stays here until go falls. Then all_done stays set, and the next rising go restarts the sequence from IDLE, clearing all_done.
- ERROR: timeout_err=1. prog_idx holds the index of the hung program. Only reset leaves this state.
- go is ignored outside IDLE and FINISH. Dropping go mid-sequence does not abort the run.
- core_pc_init always reflects PROG_BASES[prog_idx], so it is stable before and during START.
- The run counter saturates at MAX_CYCLES and never wraps.
- Latency: go to the first core_start is 1 cycle. Done to the next program's core_start is 2 cycles (RUN→LATCH→START).
- Reset asserted mid-run returns the block to IDLE immediately and drops core_start asynchronously.

Optional Feature:
Macro CYCLE_LOG_EN.
- Defined: a NUM_PROGS-entry register array stores the count of each program in LATCH at entry prog_idx. log_count = log[log_idx], combinational. All entries are cleared on reset and on leaving IDLE. log_idx >= NUM_PROGS returns 0.
- Undefined: no array is built, log_count is tied to 0, and log_idx is unused.

Decomposition:
- Package prog_seq_pkg holds:
  - the state enum seq_state_t (3-bit encoding);
  - the PC_W and CNT_W defaults;
  - the helper function base_of(PROG_BASES, idx).
- One sub-module, seq_counter: a loadable down/up saturating counter used for both the start counter and the run counter. The FSM stays in prog_sequencer.

Test Plan:
- Reset mid-RUN: assert reset at run cycle 5 → core_start=0, busy=0 and the state is IDLE the same cycle. After release, the counters read 0.
- Nominal run: PROG_BASES={0,0x100,0x200}, go=1, the core model raises done 10, 20 and 30 cycles after start falls → core_pc_init sequences 0x000, 0x100, 0x200. cycle_count reads 10, 20, 30 after each LATCH. all_done=1 after the third, with busy=0.
- Start window: START_CYCLES=2, core_done held at 1 during START → done is ignored, core_start is high for exactly 2 cycles, and the count starts at the first RUN cycle.
- Watchdog: MAX_CYCLES=50, the core never raises done on program 1 → timeout_err=1 at RUN cycle 50, prog_idx=1, and all_done stays 0.
- Simultaneous events: done arrives on exactly cycle MAX_CYCLES → LATCH is taken, there is no error, and cycle_count=MAX_CYCLES.
- CYCLE_LOG_EN: after the nominal run, log_idx=0/1/2 → log_count=10/20/30; log_idx=3 → 0. Restarting with go clears all entries.
